run_result_collector: RTL and testbench
=======================================

# run_result_collector

Downstream consumer of the controller/datapath design example. Watches the datapath outputs A, E, F and detects run completion (rising edge of F). On each completion it captures a result record {run_id, E, A} into a small show-ahead FIFO, which a reader drains through a valid/ready handshake. It also keeps a free-running run counter and a sticky overflow flag.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- CNT_W, 8: run counter / run_id width.

- clock  input  1  system clock; all state updates on posedge.
- reset_b  input  1  reset, asynchronous, active-low.
- A  input  4  datapath counter value.
- E  input  1  datapath E flag.
- F  input  1  datapath F flag; a 0→1 transition marks run completion.
- rd_ready  input  1  reader accepts the head entry this cycle.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- rd_valid  output  1  FIFO not empty.
- rd_data  output  CNT_W+5  head entry {run_id[CNT_W-1:0], E, A[3:0]}.
- level  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- run_count  output  CNT_W  completions detected since reset, modulo 2^CNT_W.
- overflow  output  1  sticky: a completion was dropped because the FIFO was full.

## Operation
- Edge detect: register f_q <= F.
  - capture = F & ~f_q.
  - f_q resets to 1, so F already high (or unknown-then-high) at reset release never counts. A capture requires F observed 0 and then 1.
- On capture:
  - The record is {run_count (value before increment), E, A}, all sampled at that edge.
  - run_count increments unconditionally and wraps from 2^CNT_W-1 to 0.
- Push: capture & (~full | pop). If the FIFO is full and pops in the same cycle, the push is accepted and level is unchanged.
- Pop: rd_valid & rd_ready. rd_ready while empty has no effect.
- Drop: capture & full & ~pop.
  - The record is discarded and overflow is set.
  - run_count still increments, so the reader can see the run_id gap.
- Overflow precedence: clr_ovf clears overflow, but set wins if a drop occurs in the same cycle.
- FIFO is circular with wr_ptr/rd_ptr of log2(DEPTH) bits and a separate level counter.
  - full = (level == DEPTH), empty = (level == 0).
  - Simultaneous push and pop: level unchanged, both pointers advance.
- Show-ahead: rd_data reflects storage[rd_ptr] combinationally. rd_data holds its value while rd_valid & ~rd_ready. rd_data is don't-care when empty.
- Reset (asynchronous, any time, including mid-transfer):
  - level = 0, pointers = 0, rd_valid = 0, run_count = 0, overflow = 0, f_q = 1.
  - Storage contents are not reset.

## Timing
- Capture latency: F high at edge k with f_q = 0 → entry written at edge k; rd_valid = 1 and rd_data valid after edge k (one cycle from F sampled high).
- With the standard datapath, F rises one clock after the S_1→S_2 transition. The expected capture is A = 4'b1101, E = 1.
- F held high for many cycles produces exactly one capture. F must return low for ≥ 1 sampled edge before the next capture.
- Back-to-back captures are possible every 2 cycles (F toggling). Sustained throughput is bounded by the reader at 1 pop/cycle.
- level, overflow and run_count are registered outputs and update on the same edge as the event causing them.

## Test plan
- Reset with F = 1, release, hold F = 1 for 10 cycles → no capture; rd_valid = 0, run_count = 0.
- F 0→1 with A = 4'b1101, E = 1, rd_ready = 0 → after that edge: rd_valid = 1, rd_data = {8'd0, 1'b1, 4'b1101}, level = 1, run_count = 1. rd_data is stable until rd_ready = 1, then rd_valid = 0 one edge later.
- 5 completions with A = 1..5, rd_ready = 0, DEPTH = 4 → level = 4, overflow = 1, run_count = 5. Draining yields run_ids 0..3 in order with A = 1..4. Asserting clr_ovf then clears overflow.
- FIFO full with a capture and rd_ready = 1 on the same edge → push accepted, level stays 4, overflow stays 0. The new entry is read last.
- Force run_count to wrap: 256 completions with the reader always ready → run_count = 0; the 256th entry carries run_id = 8'd255.
- Assert reset_b low mid-stream with level = 3, asynchronously between edges → level = 0, rd_valid = 0, overflow = 0 immediately. The first capture after release carries run_id 0.

Source files
------------

// File: rtl/run_result_collector.sv
// run_result_collector: captures {run_id, E, A} on each rising edge of F into a
// show-ahead FIFO drained by valid/ready; keeps a run counter and a sticky overflow flag.
module run_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset_b,
    input  logic [3:0]                 A,
    input  logic                       E,
    input  logic                       F,
    input  logic                       rd_ready,
    input  logic                       clr_ovf,
    output logic                       rd_valid,
    output logic [CNT_W+4:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           run_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic              f_q;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W+4:0]  mem [DEPTH];
    logic              capture, full, pop, push, drop;

    assign capture  = F & ~f_q;
    assign full     = level == LW'(DEPTH);
    assign rd_valid = level != '0;
    assign pop      = rd_valid & rd_ready;
    assign push     = capture & (~full | pop);
    assign drop     = capture & full & ~pop;
    assign rd_data  = mem[rd_ptr];

    // f_q resets high so a level-high F at reset release is not a completion
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            f_q       <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            run_count <= '0;
            overflow  <= 1'b0;
        end else begin
            f_q       <= F;
            wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
            level     <= level + LW'(push) - LW'(pop);
            run_count <= capture ? run_count + CNT_W'(1) : run_count;
            overflow  <= drop | (overflow & ~clr_ovf);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {run_count, E, A};
    end
endmodule

// File: tb/tb_run_result_collector.sv
// tb_run_result_collector: directed scenarios with hand-computed expectations.
module tb_run_result_collector;
    logic        clock = 1'b0;
    logic        reset_b, E, F, rd_ready, clr_ovf;
    logic [3:0]  A;
    logic        rd_valid, overflow;
    logic [12:0] rd_data;
    logic [2:0]  level;
    logic [7:0]  run_count;
    int          checks = 0;
    int          errors = 0;

    run_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
        .clock(clock), .reset_b(reset_b), .A(A), .E(E), .F(F),
        .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
        .rd_data(rd_data), .level(level), .run_count(run_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_b = 1'b0; F = 1'b1; A = 4'h0; E = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        #13;
        reset_b = 1'b1;
        tick();
    endtask

    // one completion: F low for one edge, then high (capture on the second edge)
    task automatic complete(input logic [3:0] a, input logic e);
        F = 1'b0; A = a; E = e;
        tick();
        F = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_b = 1'b0; F = 1'b1; A = 4'hD; E = 1'b1; rd_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        checks++;
        if (level !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_state level=%0d rd_valid=%0b overflow=%0b expected 0 0 0", level, rd_valid, overflow);
        end
        reset_b = 1'b1;
        repeat (10) tick();
        checks++;
        if (rd_valid !== 1'b0 || run_count !== 8'd0) begin
            errors++; $display("FAIL f_high_at_release rd_valid=%0b run_count=%0d expected 0 0", rd_valid, run_count);
        end
    endtask

    task automatic test_single();
        logic [12:0] exp_d;
        do_reset();
        exp_d = {8'd0, 1'b1, 4'hD};
        complete(4'hD, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d || level !== 3'd1 || run_count !== 8'd1) begin
            errors++; $display("FAIL single_capture valid=%0b data=%h level=%0d cnt=%0d expected 1 %h 1 1", rd_valid, rd_data, level, run_count, exp_d);
        end
        A = 4'h3; E = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
            errors++; $display("FAIL hold_stable valid=%0b data=%h expected 1 %h", rd_valid, rd_data, exp_d);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL single_pop valid=%0b level=%0d expected 0 0", rd_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) complete(4'(i), 1'b0);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1 || run_count !== 8'd5) begin
            errors++; $display("FAIL overflow_fill level=%0d ovf=%0b cnt=%0d expected 4 1 5", level, overflow, run_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== {i[7:0], 1'b0, 4'(i + 1)}) begin
                errors++; $display("FAIL drain_%0d valid=%0b data=%h expected 1 %h", i, rd_valid, rd_data, {i[7:0], 1'b0, 4'(i + 1)});
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL drained valid=%0b ovf=%0b expected 0 1", rd_valid, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clr_ovf ovf=%0b expected 0", overflow);
        end
        for (int i = 0; i < 4; i++) complete(4'(i), 1'b1);
        // drop on the same edge as clr_ovf: set must win
        F = 1'b0;
        tick();
        F = 1'b1; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 3'd4 || run_count !== 8'd10) begin
            errors++; $display("FAIL set_beats_clear ovf=%0b level=%0d cnt=%0d expected 1 4 10", overflow, level, run_count);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) complete(4'(i), 1'b1);
        F = 1'b0;
        tick();
        F = 1'b1; A = 4'h9; E = 1'b1; rd_ready = 1'b1;
        tick();
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0 || run_count !== 8'd5) begin
            errors++; $display("FAIL full_pop_push level=%0d ovf=%0b cnt=%0d expected 4 0 5", level, overflow, run_count);
        end
        for (int i = 1; i <= 4; i++) begin
            logic [12:0] exp_d;
            exp_d = (i == 4) ? {8'd4, 1'b1, 4'h9} : {i[7:0], 1'b1, 4'(i + 1)};
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
                errors++; $display("FAIL full_pop_order_%0d valid=%0b data=%h expected 1 %h", i, rd_valid, rd_data, exp_d);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL full_pop_empty valid=%0b expected 0", rd_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 255; i++) complete(4'(i), 1'b0);
        complete(4'hA, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {8'd255, 1'b1, 4'hA} || run_count !== 8'd0) begin
            errors++; $display("FAIL wrap valid=%0b data=%h cnt=%0d expected 1 %h 0", rd_valid, rd_data, run_count, {8'd255, 1'b1, 4'hA});
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 5; i++) complete(4'(i), 1'b0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if (level !== 3'd3 || overflow !== 1'b1) begin
            errors++; $display("FAIL pre_async level=%0d ovf=%0b expected 3 1", level, overflow);
        end
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || run_count !== 8'd0) begin
            errors++; $display("FAIL async_reset level=%0d valid=%0b ovf=%0b cnt=%0d expected 0 0 0 0", level, rd_valid, overflow, run_count);
        end
        #4 reset_b = 1'b1;
        complete(4'h7, 1'b1);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== {8'd0, 1'b1, 4'h7} || level !== 3'd1) begin
            errors++; $display("FAIL post_reset_capture valid=%0b data=%h level=%0d expected 1 %h 1", rd_valid, rd_data, level, {8'd0, 1'b1, 4'h7});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
